// File: rtl/fifo_ser_pkg.sv
// Shared constants and types for the FIFO word serializer.
package fifo_ser_pkg;

   // Default FIFO word width, which is also the number of bits sent per word.
   localparam int DEFAULT_DATA_WIDTH = 32;

   // Serializer FSM state encoding.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_ISSUE   = 2'd1;
   localparam state_t ST_CAPTURE = 2'd2;
   localparam state_t ST_SHIFT   = 2'd3;

   // Width of a counter that indexes DATA_WIDTH bits.
   // A 1-bit word still gets a 1-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register with a selectable shift direction.
module piso_shift #(
   parameter int DATA_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  shift_en,
   output logic                  head
);

   logic [DATA_WIDTH-1:0] reg_q;
   logic [DATA_WIDTH-1:0] reg_d;

   // Next shift register value: a load wins over a shift.
   always_comb begin
      // NOTE: default first so every path assigns reg_d and no latch is inferred.
      reg_d = reg_q;
      if (load) begin
         reg_d = load_data;
      end else if (shift_en) begin
         reg_d = MSB_FIRST ? (reg_q << 1) : (reg_q >> 1);
      end
   end

   // Shift register storage, cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
      if (rst) begin
         reg_q <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   // The head bit is the next bit to go out on the serial line.
   assign head = MSB_FIRST ? reg_q[DATA_WIDTH-1] : reg_q[0];

endmodule

// File: rtl/fifo_word_serializer.sv
// Reads words one at a time from a fifo_sync and shifts each one out serially
// with a valid/ready handshake.
module fifo_word_serializer
   import fifo_ser_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter bit MSB_FIRST  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_cs,
   output logic                  fifo_rd_en,
   input  logic                  tx_ready,
   output logic                  tx_data,
   output logic                  tx_valid,
   output logic                  tx_last,
   output logic                  busy,
   output logic [15:0]           words_sent
);

   localparam int CNT_W = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      words_q, words_d;
   logic             head;
   logic             fire;
   logic             last_bit;

   // A bit moves only on a SHIFT cycle where the receiver is ready.
   assign fire     = (state_q == ST_SHIFT) && tx_ready;
   assign last_bit = (cnt_q == LAST_IDX);

   piso_shift #(
      .DATA_WIDTH (DATA_WIDTH),
      .MSB_FIRST  (MSB_FIRST)
   ) u_piso (
      .clk       (clk),
      .rst       (rst),
      .load      (state_q == ST_CAPTURE),
      .load_data (fifo_data_out),
      .shift_en  (fire),
      .head      (head)
   );

   // State, bit counter and word counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         words_q <= words_d;
      end
   end

   // Next-state logic: one read per word, and the next word is fetched only after the last bit goes out.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (!fifo_empty) state_d = ST_ISSUE;
         ST_ISSUE:   state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_SHIFT;
         ST_SHIFT:   if (fire && last_bit) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Bit counter and completed-word counter; the word counter wraps naturally.
   always_comb begin
      cnt_d   = cnt_q;
      words_d = words_q;
      if (state_q == ST_CAPTURE) begin
         cnt_d = '0;
      end else if (fire) begin
         cnt_d = last_bit ? '0 : cnt_q + 1'b1;
         if (last_bit) begin
            words_d = words_q + 16'd1;
         end
      end
   end

   // Outputs decoded from the current state only.
   always_comb begin
      fifo_rd_en = (state_q == ST_ISSUE);
      tx_valid   = (state_q == ST_SHIFT);
      tx_data    = tx_valid & head;
      tx_last    = tx_valid & last_bit;
      busy       = (state_q != ST_IDLE);
   end

   // Chip select is held active whenever the block is out of reset.
   assign fifo_cs    = ~rst;
   assign words_sent = words_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed testbench for fifo_word_serializer (DATA_WIDTH=32, MSB first).
module tb_fifo_word_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic [31:0] fifo_data_out;
   logic        fifo_cs;
   logic        fifo_rd_en;
   logic        tx_ready;
   logic        tx_data;
   logic        tx_valid;
   logic        tx_last;
   logic        busy;
   logic [15:0] words_sent;

   int n_cmp = 0;
   int n_bad = 0;

   // Small FIFO model: the bench pushes, the read port pops on rd_en.
   logic [31:0] mem [16];
   logic [3:0]  wr_ptr = '0;
   logic [3:0]  rd_ptr = '0;
   int          rd_cnt = 0;
   int          underflow = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always #5 clk = ~clk;

   fifo_word_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_cs       (fifo_cs),
      .fifo_rd_en    (fifo_rd_en),
      .tx_ready      (tx_ready),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_last       (tx_last),
      .busy          (busy),
      .words_sent    (words_sent)
   );

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         rd_cnt <= rd_cnt + 1;
         if (wr_ptr == rd_ptr) underflow <= underflow + 1;
         fifo_data_out <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 4'd1;
      end
   end

   task automatic push(input logic [31:0] w);
      mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 4'd1;
   endtask

   // Receives one word starting at a negedge, MSB first. Reports cycles before the first
   // valid, SHIFT cycles, tx_last errors, and stall-stability or dropped-valid errors.
   task automatic collect(input bit toggle, output logic [31:0] word, output int wait_cyc,
                          output int shift_cyc, output int last_err, output int stall_err,
                          output bit timeout);
      int   bits;
      bit   prev_stall;
      logic prev_data, prev_last;
      word = '0; wait_cyc = 0; shift_cyc = 0; last_err = 0; stall_err = 0; timeout = 1'b0;
      bits = 0; prev_stall = 1'b0; prev_data = 1'b0; prev_last = 1'b0;
      for (int guard = 0; guard < 300; guard++) begin
         tx_ready = toggle ? shift_cyc[0] : 1'b1;
         #1;
         if (tx_valid) begin
            if (prev_stall && (tx_data !== prev_data || tx_last !== prev_last)) stall_err++;
            shift_cyc++;
            if (tx_ready) begin
               if (tx_last !== (bits == 31)) last_err++;
               word = {word[30:0], tx_data};
               bits++;
               prev_stall = 1'b0;
            end else begin
               prev_stall = 1'b1;
               prev_data  = tx_data;
               prev_last  = tx_last;
            end
         end else if (bits == 0) begin
            wait_cyc++;
         end else begin
            stall_err++;
         end
         if (bits == 32) return;
         @(negedge clk);
      end
      timeout = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tx_ready = 1'b1;
      push(32'h0000_0001);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         n_cmp++;
         if ({fifo_cs, fifo_rd_en, tx_data, tx_valid, tx_last, busy, words_sent} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs[%0d]: got cs=%b rd=%b d=%b v=%b l=%b busy=%b ws=%h want all 0",
                     i, fifo_cs, fifo_rd_en, tx_data, tx_valid, tx_last, busy, words_sent);
         end
      end
      n_cmp++;
      if (rd_cnt !== 0) begin
         n_bad++;
         $display("FAIL reset_no_read: got %0d reads want 0", rd_cnt);
      end
   endtask

   task automatic test_single_word();
      logic [31:0] w; int wc, sc, le, se; bit to;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({fifo_cs, fifo_rd_en, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL release_idle: got cs/rd/busy=%b want 100", {fifo_cs, fifo_rd_en, busy});
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({fifo_rd_en, busy, tx_valid} !== 3'b110) begin
         n_bad++;
         $display("FAIL single_issue: got rd/busy/valid=%b want 110", {fifo_rd_en, busy, tx_valid});
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({fifo_rd_en, busy, tx_valid} !== 3'b010) begin
         n_bad++;
         $display("FAIL single_capture: got rd/busy/valid=%b want 010", {fifo_rd_en, busy, tx_valid});
      end
      @(negedge clk);
      collect(1'b0, w, wc, sc, le, se, to);
      n_cmp++;
      if (to || w !== 32'h0000_0001 || wc !== 0 || sc !== 32 || le !== 0 || se !== 0) begin
         n_bad++;
         $display("FAIL single_word: got word=%h wait=%0d shift=%0d last_err=%0d err=%0d to=%b want 00000001/0/32/0/0/0",
                  w, wc, sc, le, se, to);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (words_sent !== 16'd1 || busy !== 1'b0 || tx_valid !== 1'b0 || rd_cnt !== 1) begin
         n_bad++;
         $display("FAIL single_done: got ws=%0d busy=%b valid=%b reads=%0d want 1/0/0/1",
                  words_sent, busy, tx_valid, rd_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w; int wc, sc, le, se; bit to;
      @(negedge clk);
      push(32'hA5A5_A5A5);
      collect(1'b1, w, wc, sc, le, se, to);
      n_cmp++;
      if (to || w !== 32'hA5A5_A5A5 || sc !== 64 || le !== 0 || se !== 0) begin
         n_bad++;
         $display("FAIL backpressure: got word=%h shift=%0d last_err=%0d stall_err=%0d to=%b want a5a5a5a5/64/0/0/0",
                  w, sc, le, se, to);
      end
      n_cmp++;
      if (wc !== 3) begin
         n_bad++;
         $display("FAIL latency: got %0d cycles to first valid want 3", wc);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (words_sent !== 16'd2 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL backpressure_done: got ws=%0d busy=%b want 2/0", words_sent, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w; int wc, sc, le, se; bit to;
      logic [31:0] exp_w [3];
      int          exp_wait [3];
      int          rd0;
      exp_w[0] = 32'd1;  exp_w[1] = 32'd10; exp_w[2] = 32'd100;
      exp_wait[0] = 3;   exp_wait[1] = 2;   exp_wait[2] = 2;
      @(negedge clk);
      rd0 = rd_cnt;
      for (int k = 0; k < 3; k++) push(exp_w[k]);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         collect(1'b0, w, wc, sc, le, se, to);
         n_cmp++;
         if (to || w !== exp_w[k] || wc !== exp_wait[k] || le !== 0 || se !== 0) begin
            n_bad++;
            $display("FAIL b2b_word[%0d]: got word=%h gap=%0d last_err=%0d err=%0d to=%b want %h gap=%0d",
                     k, w, wc, le, se, to, exp_w[k], exp_wait[k]);
         end
      end
      repeat (6) @(negedge clk);
      #1;
      n_cmp++;
      if (words_sent !== 16'd5 || rd_cnt - rd0 !== 3 || busy !== 1'b0 || underflow !== 0) begin
         n_bad++;
         $display("FAIL b2b_done: got ws=%0d reads=%0d busy=%b underflow=%0d want 5/3/0/0",
                  words_sent, rd_cnt - rd0, busy, underflow);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] w; int wc, sc, le, se; bit to;
      int          rd0;
      @(negedge clk);
      rd0 = rd_cnt;
      tx_ready = 1'b1;
      push(32'hFFFF_0000);
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if (tx_valid !== 1'b1 || tx_data !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_first_bit: got valid=%b data=%b want 1/1", tx_valid, tx_data);
      end
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({fifo_cs, fifo_rd_en, tx_data, tx_valid, tx_last, busy, words_sent} !== 22'd0) begin
         n_bad++;
         $display("FAIL midreset_clear: got cs=%b rd=%b d=%b v=%b l=%b busy=%b ws=%h want all 0",
                  fifo_cs, fifo_rd_en, tx_data, tx_valid, tx_last, busy, words_sent);
      end
      @(negedge clk);
      rst = 1'b0;
      push(32'h1234_5678);
      collect(1'b0, w, wc, sc, le, se, to);
      n_cmp++;
      if (to || w !== 32'h1234_5678 || wc !== 3 || le !== 0 || se !== 0) begin
         n_bad++;
         $display("FAIL midreset_next_word: got word=%h wait=%0d last_err=%0d err=%0d to=%b want 12345678/3",
                  w, wc, le, se, to);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (words_sent !== 16'd1 || rd_cnt - rd0 !== 2) begin
         n_bad++;
         $display("FAIL midreset_count: got ws=%0d reads=%0d want 1/2", words_sent, rd_cnt - rd0);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] w; int wc, sc, le, se; bit to;
      @(negedge clk);
      force dut.words_q = 16'hFFFE;
      @(negedge clk);
      release dut.words_q;
      #1;
      n_cmp++;
      if (words_sent !== 16'hFFFE) begin
         n_bad++;
         $display("FAIL wrap_preload: got %h want fffe", words_sent);
      end
      push(32'h0000_0003);
      push(32'h8000_0000);
      collect(1'b0, w, wc, sc, le, se, to);
      n_cmp++;
      if (to || w !== 32'h0000_0003) begin
         n_bad++;
         $display("FAIL wrap_word0: got %h to=%b want 00000003", w, to);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (words_sent !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL wrap_ffff: got %h want ffff", words_sent);
      end
      collect(1'b0, w, wc, sc, le, se, to);
      n_cmp++;
      if (to || w !== 32'h8000_0000 || wc !== 2) begin
         n_bad++;
         $display("FAIL wrap_word1: got %h gap=%0d to=%b want 80000000 gap=2", w, wc, to);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (words_sent !== 16'h0000) begin
         n_bad++;
         $display("FAIL wrap_zero: got %h want 0000", words_sent);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_word_serializer.md
FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: FIFO word width and bits shifted per word.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit DATA_WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port fifo_empty, input, 1: empty flag from the upstream fifo_sync.
REQ-006 SHALL have port fifo_data_out, input, DATA_WIDTH: fifo_sync read data, valid the cycle after a rd_en cycle.
REQ-007 SHALL have port fifo_cs, output, 1: chip select to fifo_sync.
REQ-008 SHALL have port fifo_rd_en, output, 1: read strobe to fifo_sync.
REQ-009 SHALL have port tx_ready, input, 1: downstream accepts the current bit.
REQ-010 SHALL have port tx_data, output, 1: serial bit.
REQ-011 SHALL have port tx_valid, output, 1: tx_data is valid.
REQ-012 SHALL have port tx_last, output, 1: current bit is the final bit of a word.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port words_sent, output, 16: count of completed words; wraps from 16'hFFFF to 0.

Function
REQ-015 SHALL implement the FSM states IDLE, ISSUE, CAPTURE and SHIFT.
REQ-016 IDLE SHALL move to ISSUE when fifo_empty=0, and SHALL otherwise remain in IDLE with fifo_rd_en=0.
REQ-017 ISSUE SHALL last exactly one cycle, drive fifo_rd_en=1, and move to CAPTURE.
REQ-018 CAPTURE SHALL load fifo_data_out into the shift register and clear the bit counter, then move to SHIFT.
REQ-019 fifo_rd_en SHALL be high only in ISSUE, so at most one read is in flight and no read is issued while fifo_empty=1.
REQ-020 fifo_cs SHALL be 1 in every cycle out of reset.
REQ-021 SHIFT SHALL drive tx_valid=1 with tx_data equal to the current head bit, selected by MSB_FIRST.
REQ-022 In SHIFT, tx_data and tx_last SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-023 A bit SHALL be transferred only on a cycle with tx_valid=1 and tx_ready=1; the shift register and the bit counter then advance by one.
REQ-024 tx_last SHALL be 1 exactly when the bit counter equals DATA_WIDTH-1 in SHIFT.
REQ-025 On transfer of the last bit, words_sent SHALL increment.
REQ-026 On transfer of the last bit, the FSM SHALL go to ISSUE if fifo_empty=0, else to IDLE.
REQ-027 Latency: fifo_empty falling while in IDLE in cycle n SHALL give the first tx_valid in cycle n+3.
REQ-028 Back-to-back words SHALL have exactly 2 non-valid cycles between them (ISSUE, CAPTURE).
REQ-029 The bit counter SHALL be clog2(DATA_WIDTH) bits wide and SHALL never exceed DATA_WIDTH-1.
REQ-030 Outside SHIFT, tx_valid, tx_last and tx_data SHALL be 0.
REQ-031 tx_ready SHALL be ignored outside SHIFT.

Reset
REQ-032 Reset SHALL force state=IDLE, shift register=0, bit counter=0 and words_sent=0.
REQ-033 Reset SHALL force fifo_cs, fifo_rd_en, tx_data, tx_valid, tx_last and busy to 0.
REQ-034 Reset asserted mid-word SHALL abandon the partial word with no words_sent increment, and that word SHALL NOT be re-read.
REQ-035 After reset release, the first possible fifo_rd_en SHALL be in the second cycle (IDLE then ISSUE).

Structure
REQ-036 Package fifo_ser_pkg SHALL hold the state encoding localparams (2-bit) and the default DATA_WIDTH constant.
REQ-037 Sub-module piso_shift (parallel load, enable-shift, MSB_FIRST parameter, head-bit output) SHALL hold the shift register.
REQ-038 The FSM, the bit counter and words_sent SHALL be in the top level.

Verification
REQ-039 Reset scenario: hold rst=1 with fifo_empty=0 -> all outputs 0, no fifo_rd_en pulse.
REQ-040 Single-word scenario: FIFO holds 32'h0000_0001, tx_ready=1, MSB_FIRST=1 -> rd_en pulse in 1 cycle, 31 zeros then a 1 with tx_last on bit 32, words_sent=1, then IDLE.
REQ-041 Backpressure scenario: word 32'hA5A5_A5A5 with tx_ready toggling every cycle -> bit sequence intact, outputs stable while stalled, 64 SHIFT cycles.
REQ-042 Back-to-back scenario: FIFO holds 1, 10, 100 -> three rd_en pulses, exactly 2-cycle gaps, words_sent=3, final fifo_empty=1 with no extra read.
REQ-043 Mid-word reset scenario: assert rst after 10 bits of 32'hFFFF_0000 -> immediate return to IDLE, words_sent=0; the next FIFO word is serialized whole.
REQ-044 Wrap scenario: preload or run 65536 words -> words_sent wraps to 0.
